matrix_scan: RTL and testbench
==============================

MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks per scanned row; legal range 4..65535.
REQ-002 Parameter GUARD, default 4: blanking clocks at the start of each row; legal range 1..SCAN_DIV-2.
REQ-003 Parameter HOLD_FRAMES, default 8: full frames shown after finish before clearing; legal range 1..255.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 note_R  input  10  red note row from shift_load for row index offset.
REQ-007 note_G  input  10  green note row from shift_load for row index offset.
REQ-008 offset  input  4  row index currently presented by shift_load.
REQ-009 finish  input  1  level from shift_load; high marks the end of the song.
REQ-010 row_en  output  16  one-hot row drive, active-high.
REQ-011 col_R  output  10  red column drive, active-low.
REQ-012 col_G  output  10  green column drive, active-low.
REQ-013 frame_done  output  1  single-cycle pulse at the end of every scanned frame.
REQ-014 busy  output  1  high in RUN and DRAIN.

Function
REQ-015 The block SHALL hold a 16x10 red buffer and a 16x10 green buffer; both are cleared to 0 by reset.
REQ-016 The block SHALL register offset each cycle as offset_q, which resets to 0; a change event is offset != offset_q.
REQ-017 FSM states SHALL be IDLE, RUN and DRAIN; reset state is IDLE.
REQ-018 IDLE: the scan is halted; row_en=0, col_R=col_G=all ones, busy=0.
REQ-019 IDLE to RUN SHALL occur on the first change event; that event's row is written.
REQ-020 RUN: on each change event the block SHALL write note_R and note_G into buffer row offset in the same edge.
REQ-021 RUN to DRAIN SHALL occur on a rising edge of finish, detected against a registered copy.
  - If a change event occurs in the same cycle, the write is still performed.
REQ-022 DRAIN: buffer writes are ignored; scanning continues.
  - After HOLD_FRAMES frame_done pulses, the buffers clear to 0 in one cycle and the FSM enters IDLE.
REQ-023 Scan counters: div_cnt runs 0..SCAN_DIV-1; row_idx runs 0..15.
  - At div_cnt=SCAN_DIV-1, div_cnt wraps to 0 and row_idx increments modulo 16.
REQ-024 frame_done SHALL pulse in the cycle where div_cnt=SCAN_DIV-1 and row_idx=15, in RUN or DRAIN only.
REQ-025 Row latch: at div_cnt=0 the block SHALL latch the buffer rows for row_idx into a column register.
  - The column register is not updated mid-row, so no tearing.
  - A write to the row being scanned becomes visible on that row's next visit.
REQ-026 Blanking: when div_cnt<GUARD, row_en=0 and col_R=col_G=all ones.
  - Otherwise row_en=1<<row_idx, col_R=~latched_R and col_G=~latched_G.
REQ-027 All outputs SHALL be registered.
  - Total latency from counter state to pins is exactly 1 clock.
REQ-028 Entering RUN from IDLE SHALL restart the scan at div_cnt=0 and row_idx=0.
REQ-029 A finish that stays high SHALL NOT retrigger DRAIN.
  - finish high while in IDLE or already in DRAIN SHALL be ignored.
REQ-030 A change event in DRAIN SHALL be ignored and SHALL NOT leave DRAIN.
  - A new song requires finish to fall, then a change event after the FSM returns to IDLE.

Reset
REQ-031 While rst=0, asynchronously: state=IDLE, counters=0, buffers=0, offset_q=0, finish_q=0, row_en=0, col_R=col_G=10'h3FF, frame_done=0, busy=0.
REQ-032 Deassertion of rst SHALL take effect at the next rising edge with no spurious frame_done or write.
REQ-033 Reset asserted mid-frame or mid-DRAIN SHALL abandon the frame and clear all buffers.

Verification (SCAN_DIV=4, GUARD=1, HOLD_FRAMES=2)
REQ-034 Reset, then offset 0->1 with note_R=10'h201 -> busy=1; row 1 latched on its first visit; during row 1's div_cnt 1..3, row_en=16'h0002 and col_R=10'h1FE.
REQ-035 Free-run in RUN -> frame_done pulses every 64 clocks; row_en=0 in each row's first cycle; exactly one row_en bit set otherwise.
REQ-036 Write row 5 (note_G=10'h3FF) while row_idx=5 and div_cnt=2 -> col_G unchanged for the rest of that row; col_G=10'h000 on the next row 5 visit.
REQ-037 finish rises together with offset 7->8 and note_R=10'h00F -> row 8 red=10'h00F; exactly 2 frame_done pulses follow; then buffers=0, busy=0, row_en=0.
REQ-038 finish held high after the return to IDLE, plus offset changes during DRAIN -> no writes, no second DRAIN, IDLE persists until finish falls and a change event occurs.
REQ-039 rst pulsed low at row_idx=9 in RUN -> outputs reach reset values immediately; a later change event starts the scan at row 0 with all other rows blank.

Source files
------------

// File: rtl/matrix_scan.sv
// Row-multiplexed red/green LED matrix scanner: latches note rows into a 16x10 frame buffer
// while a song plays, scans it with per-row blanking, then holds the picture for a few frames.
module matrix_scan #(
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD       = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  note_R,
  input  logic [9:0]  note_G,
  input  logic [3:0]  offset,
  input  logic        finish,
  output logic [15:0] row_en,
  output logic [9:0]  col_R,
  output logic [9:0]  col_G,
  output logic        frame_done,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);
  localparam logic [15:0] GUARD_W = 16'(GUARD);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  logic [1:0]  r_state;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_row_idx;
  logic [7:0]  r_drain_cnt;
  logic [3:0]  r_offset_q;
  logic        r_finish_q;
  logic [9:0]  r_buf_r [16];
  logic [9:0]  r_buf_g [16];
  logic [9:0]  r_lat_r;
  logic [9:0]  r_lat_g;
  logic [15:0] r_row_en;
  logic [9:0]  r_col_r;
  logic [9:0]  r_col_g;
  logic        r_frame_done;
  logic        r_busy;

  logic w_change;
  logic w_fin_rise;
  logic w_row_end;
  logic w_frame_end;
  logic w_write;
  logic w_drain_done;

  assign w_change     = (offset != r_offset_q);
  assign w_fin_rise   = finish & ~r_finish_q;
  assign w_row_end    = (r_div_cnt == DIV_MAX);
  assign w_frame_end  = w_row_end && (r_row_idx == 4'hF) && (r_state != S_IDLE);
  // A song may only start once finish has dropped; DRAIN never accepts writes.
  assign w_write      = w_change && (((r_state == S_IDLE) && !finish) || (r_state == S_RUN));
  assign w_drain_done = (r_state == S_DRAIN) && w_frame_end && (r_drain_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 8'd0;
      r_offset_q  <= 4'd0;
      r_finish_q  <= 1'b0;
    end else begin
      r_offset_q <= offset;
      r_finish_q <= finish;
      case (r_state)
        S_IDLE: if (w_write) r_state <= S_RUN;
        S_RUN: begin
          if (w_fin_rise) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 8'd0;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) r_state <= S_IDLE;
          else if (w_frame_end) r_drain_cnt <= r_drain_cnt + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counters sit at zero while idle so the first RUN cycle always starts a fresh frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= 16'd0;
      r_row_idx <= 4'd0;
    end else if ((r_state == S_IDLE) || w_drain_done) begin
      r_div_cnt <= 16'd0;
      r_row_idx <= 4'd0;
    end else if (w_row_end) begin
      r_div_cnt <= 16'd0;
      r_row_idx <= r_row_idx + 4'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        r_buf_r[i] <= 10'd0;
        r_buf_g[i] <= 10'd0;
      end
    end else if (w_drain_done) begin
      for (int i = 0; i < 16; i++) begin
        r_buf_r[i] <= 10'd0;
        r_buf_g[i] <= 10'd0;
      end
    end else if (w_write) begin
      r_buf_r[offset] <= note_R;
      r_buf_g[offset] <= note_G;
    end
  end

  // Row data is captured once per row, so a write never tears the row currently shown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_r <= 10'd0;
      r_lat_g <= 10'd0;
    end else if (r_div_cnt == 16'd0) begin
      r_lat_r <= r_buf_r[r_row_idx];
      r_lat_g <= r_buf_g[r_row_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_en     <= 16'd0;
      r_col_r      <= 10'h3FF;
      r_col_g      <= 10'h3FF;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_busy       <= (r_state != S_IDLE);
      if ((r_state == S_IDLE) || (r_div_cnt < GUARD_W)) begin
        r_row_en <= 16'd0;
        r_col_r  <= 10'h3FF;
        r_col_g  <= 10'h3FF;
      end else begin
        r_row_en <= 16'd1 << r_row_idx;
        r_col_r  <= ~r_lat_r;
        r_col_g  <= ~r_lat_g;
      end
    end
  end

  assign row_en     = r_row_en;
  assign col_R      = r_col_r;
  assign col_G      = r_col_g;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_matrix_scan.sv
// Bench for matrix_scan: directed song scenarios plus random traffic, checked every cycle
// against a scan-position model of the display.
module tb_matrix_scan;

  localparam int SD   = 4;
  localparam int GD   = 1;
  localparam int HF   = 2;
  localparam int NPOS = 16 * SD;
  localparam int W    = 38;
  localparam logic [W-1:0] RESET_VEC = {16'h0000, 10'h3FF, 10'h3FF, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  note_R, note_G;
  logic [3:0]  offset;
  logic        finish;
  logic [15:0] row_en;
  logic [9:0]  col_R, col_G;
  logic        frame_done, busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Model: mode 0 idle, 1 playing, 2 holding; m_pos = cycles into the current frame.
  int         m_mode, m_pos, m_frames_left;
  logic [9:0] m_buf_r [16];
  logic [9:0] m_buf_g [16];
  logic [9:0] m_lat_r, m_lat_g;
  logic [3:0] m_off;
  logic       m_fin;

  matrix_scan #(.SCAN_DIV(SD), .GUARD(GD), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .note_R(note_R), .note_G(note_G), .offset(offset),
    .finish(finish), .row_en(row_en), .col_R(col_R), .col_G(col_G),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_frames_left = 0;
    for (int i = 0; i < 16; i++) begin m_buf_r[i] = 10'd0; m_buf_g[i] = 10'd0; end
    m_lat_r = 10'd0; m_lat_g = 10'd0; m_off = 4'd0; m_fin = 1'b0;
  endtask

  function automatic logic [W-1:0] model_pins();
    logic [15:0] re; logic [9:0] cr, cg; logic fd, bz;
    re = 16'h0; cr = 10'h3FF; cg = 10'h3FF; fd = 1'b0; bz = 1'b0;
    if (m_mode != 0) begin
      bz = 1'b1;
      fd = (m_pos == NPOS - 1);
      if ((m_pos % SD) >= GD) begin
        re = 16'h1 << (m_pos / SD);
        cr = ~m_lat_r;
        cg = ~m_lat_g;
      end
    end
    return {re, cr, cg, fd, bz};
  endfunction

  task automatic model_edge();
    logic change, rise;
    change = (offset != m_off);
    rise   = finish && !m_fin;
    case (m_mode)
      0: if (change && !finish) begin
        m_buf_r[offset] = note_R; m_buf_g[offset] = note_G;
        m_mode = 1; m_pos = 0;
      end
      1: begin
        if (m_pos % SD == 0) begin m_lat_r = m_buf_r[m_pos / SD]; m_lat_g = m_buf_g[m_pos / SD]; end
        if (change) begin m_buf_r[offset] = note_R; m_buf_g[offset] = note_G; end
        if (rise) begin m_mode = 2; m_frames_left = HF; end
        m_pos = (m_pos + 1) % NPOS;
      end
      default: begin
        if (m_pos % SD == 0) begin m_lat_r = m_buf_r[m_pos / SD]; m_lat_g = m_buf_g[m_pos / SD]; end
        if (m_pos == NPOS - 1) begin
          m_pos = 0;
          m_frames_left--;
          if (m_frames_left == 0) begin
            for (int i = 0; i < 16; i++) begin m_buf_r[i] = 10'd0; m_buf_g[i] = 10'd0; end
            m_mode = 0;
          end
        end else m_pos++;
      end
    endcase
    m_off = offset;
    m_fin = finish;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
      exp_q.push_back(RESET_VEC);
    end else begin
      exp_q.push_back(model_pins());
      model_edge();
    end
  end

  // Asynchronous reset overrides whatever the last edge predicted.
  always @(negedge rst) begin
    exp_q.delete();
    if (clk) exp_q.push_back(RESET_VEC);
  end

  always @(negedge clk) begin
    logic [W-1:0] v;
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      check("row_en", row_en, v[37:22]);
      check("col_R", col_R, v[21:12]);
      check("col_G", col_G, v[11:2]);
      check("frame_done", frame_done, v[1]);
      check("busy", busy, v[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int found;
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      tick(1);
      if (m_mode == 1 && m_pos == p) found = 1;
    end
    check("wait_pos_timeout", found, 1);
  endtask

  task automatic wait_row(input logic [15:0] row, input int budget, output int found);
    found = 0;
    for (int k = 0; k < budget && found == 0; k++) begin
      @(negedge clk);
      if (row_en == row) found = 1;
    end
  endtask

  initial begin
    int found, fd_cnt, seen8;
    logic [9:0] col8;
    rst = 1'b0; offset = 4'd0; note_R = 10'd0; note_G = 10'd0; finish = 1'b0;
    model_reset();
    tick(3);
    check("reset_state", dbg_state, 2'd0);
    rst = 1'b1;
    tick(2);

    // First change event starts the song and writes row 1.
    note_R = 10'h201; offset = 4'd1;
    tick(1);
    note_R = 10'h000;
    wait_row(16'h0002, 100, found);
    check("row1_seen", found, 1);
    check("row1_col_R", col_R, 10'h1FE);
    tick(200);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        offset = 4'($urandom_range(0, 15));
        note_R = 10'($urandom); note_G = 10'($urandom);
      end
      tick(1);
    end

    // Overwrite row 5 while it is on display; new data only on the next visit.
    offset = 4'd5; note_G = 10'h000; tick(1);
    offset = 4'd6; tick(1);
    wait_pos(22);
    offset = 4'd5; note_G = 10'h3FF;
    tick(50);
    wait_row(16'h0020, 100, found);
    check("row5_seen", found, 1);
    check("row5_col_G", col_G, 10'h000);

    // Finish rises with the last write; the picture holds for HF frames then clears.
    offset = 4'd7; note_R = 10'h000; tick(1);
    wait_pos(10);
    offset = 4'd8; note_R = 10'h00F; note_G = 10'h000; finish = 1'b1;
    fd_cnt = 0; seen8 = 0; col8 = 10'h000; found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (row_en == 16'h0100) begin seen8 = 1; col8 = col_R; end
      if (!busy && k > 2) found = 1;
      else if ($urandom_range(0, 7) == 0) offset = offset + 4'd1;
    end
    check("drain_exit", found, 1);
    check("drain_frames", fd_cnt, HF);
    check("row8_seen", seen8, 1);
    check("row8_col_R", col8, 10'h3F0);

    // finish still high: change events must not restart the song.
    offset = 4'd3; tick(5);
    offset = 4'd9; tick(5);
    check("idle_with_finish", busy, 0);
    finish = 1'b0; tick(3);
    check("idle_after_fall", busy, 0);
    offset = 4'd2; note_R = 10'h155; note_G = 10'h0AA; tick(3);
    check("restart_busy", busy, 1);

    // Reset mid-row 9.
    wait_pos(37);
    rst = 1'b0;
    #1;
    check("async_row_en", row_en, 16'h0000);
    check("async_col_R", col_R, 10'h3FF);
    check("async_busy", busy, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    offset = 4'd0; note_R = 10'h3C3; note_G = 10'h00C; tick(1);
    offset = 4'd4; note_R = 10'h000; note_G = 10'h000; tick(140);

    repeat (2500) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 40) begin
        offset = 4'($urandom_range(0, 15));
        note_R = 10'($urandom); note_G = 10'($urandom);
      end else if (r < 42) begin
        finish = ~finish;
      end else if (r == 199 && $urandom_range(0, 3) == 0) begin
        rst = 1'b0; tick(1); rst = 1'b1;
      end
      tick(1);
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
